fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Sequencing controller for the dual-slot fetch PC register. Each cycle it chooses one fetch action: a mispredict redirect from execute, a branch-predictor redirect from decode/BTB, a normal advance, or a hold. It drives the PC register's redirect, enable and target inputs. It also defers predictor redirects that arrive during a fetch stall, runs a post-mispredict squash window, and counts mispredicts.

Parameters:
WIDTH, 32, PC/address width
FLUSH_CYCLES, 2, cycles the front end is squashed after a mispredict redirect (1..15)
CNT_WIDTH, 16, width of the saturating mispredict counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
stall_i  input  1  hazard unit requests the fetch PC hold
mispredict_i  input  1  execute resolved a branch/jump as mispredicted
mispredict_pc_i  input  WIDTH  correct target for a mispredict
predict_taken_i  input  1  predictor says taken for a fetched slot
predict_slot_i  input  1  slot holding the predicted branch (0 = PCF, 1 = PCF2)
predict_pc_i  input  WIDTH  predicted target
pc_en_o  output  1  enable to the PC register
pc_redirect_o  output  1  mispredict redirect strobe to the PC register
mispredict_target_pc_o  output  WIDTH  target accompanying pc_redirect_o
pc_predict_redirect_o  output  1  predictor redirect strobe to the PC register
predicted_target_pc_o  output  WIDTH  target accompanying pc_predict_redirect_o
slot1_kill_o  output  1  invalidate the fetch slot-1 instruction this cycle
flush_o  output  1  squash fetch/decode pipeline registers
mispredict_count_o  output  CNT_WIDTH  saturating mispredict count

Behaviour:
- States: RUN, HOLD (a predictor redirect is pending), FLUSH (squash window).
- Registered state: state, pending_pc (WIDTH), flush_cnt (4 bits), mispredict_count.
- Reset (rst_n low, asynchronous):
  - state = RUN, pending_pc = 0, flush_cnt = 0, count = 0.
  - All outputs 0, including pc_en_o and all target outputs.
  - Reset takes effect immediately in any state, including mid-FLUSH or HOLD; any pending redirect is lost.
- Mispredict (highest priority, any state):
  - Combinational, same cycle: pc_redirect_o = 1 and mispredict_target_pc_o = mispredict_pc_i. This happens regardless of stall_i.
  - pc_predict_redirect_o = 0 and slot1_kill_o = 0 that cycle.
  - Next state = FLUSH with flush_cnt = FLUSH_CYCLES. Any pending predictor redirect is discarded.
  - count += 1, saturating at all-ones.
  - A mispredict arriving during FLUSH restarts flush_cnt.
- RUN, no mispredict:
  - pc_en_o = !stall_i.
  - predict_taken_i and !stall_i: pc_predict_redirect_o = 1, predicted_target_pc_o = predict_pc_i, same cycle. slot1_kill_o = (predict_slot_i == 0).
  - predict_taken_i and stall_i: pending_pc = predict_pc_i, next state = HOLD. slot1_kill_o still = (predict_slot_i == 0). No redirect strobe.
- HOLD, no mispredict:
  - Predictor inputs are ignored.
  - pc_en_o = !stall_i.
  - When stall_i = 0: pc_predict_redirect_o = 1, predicted_target_pc_o = pending_pc, next state = RUN.
  - While stall_i = 1: remain in HOLD with no strobe.
- FLUSH, no mispredict:
  - flush_o = 1 and pc_en_o = 1, independent of stall_i.
  - predict_taken_i is ignored (wrong-path) and slot1_kill_o = 0.
  - flush_cnt decrements each cycle; when it reaches 1, next state = RUN. Window length is exactly FLUSH_CYCLES cycles, starting the cycle after the mispredict.
- Strobe exclusivity:
  - pc_redirect_o and pc_predict_redirect_o are never both 1.
  - Neither strobe is asserted while rst_n is low.
- Target outputs when their strobe is 0: mispredict_target_pc_o and predicted_target_pc_o drive 0.

Test Plan:
- Reset release, no inputs active, stall_i = 0 → state RUN, pc_en_o = 1, all strobes 0, count = 0.
- RUN, predict_taken_i = 1, predict_slot_i = 0, predict_pc_i = 0x40, stall_i = 0 → same cycle: pc_predict_redirect_o = 1, predicted_target_pc_o = 0x40, slot1_kill_o = 1.
- Predict 0x80 (slot 1) with stall_i = 1 for 3 cycles:
  - Stall cycles → no strobe, pc_en_o = 0, slot1_kill_o = 0 on the first cycle.
  - First unstalled cycle → pc_predict_redirect_o = 1, target 0x80.
- Mispredict 0x100 while stalled in HOLD (pending 0x80) → same cycle pc_redirect_o = 1, target 0x100; pending dropped; then flush_o = 1 for exactly 2 cycles; no later 0x80 redirect.
- Mispredict during the first FLUSH cycle with target 0x200 → pc_redirect_o = 1, flush window restarts (2 more cycles); count increments twice total.
- Force count to 0xFFFE, apply 3 mispredicts → count holds at 0xFFFF; assert rst_n = 0 mid-FLUSH → all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Chooses the fetch action for the dual-slot fetch PC register each cycle:
// mispredict redirect, predictor redirect, normal advance, or hold. It also
// parks predictor redirects that arrive while fetch is stalled, squashes the
// front end for FLUSH_CYCLES cycles after a mispredict, and counts mispredicts.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   stall_i                  hazard unit asks the fetch PC to hold
//   mispredict_i/_pc_i       execute-stage mispredict and its correct target
//   predict_taken_i/_slot_i  predictor taken flag and the slot it applies to
//   predict_pc_i             predicted target
//   pc_en_o                  PC register enable
//   pc_redirect_o            mispredict redirect strobe (+ mispredict_target_pc_o)
//   pc_predict_redirect_o    predictor redirect strobe (+ predicted_target_pc_o)
//   slot1_kill_o             invalidate the slot-1 instruction this cycle
//   flush_o                  squash fetch/decode pipeline registers
//   mispredict_count_o       saturating mispredict count
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 mispredict_i,
    input  logic [WIDTH-1:0]     mispredict_pc_i,
    input  logic                 predict_taken_i,
    input  logic                 predict_slot_i,
    input  logic [WIDTH-1:0]     predict_pc_i,
    output logic                 pc_en_o,
    output logic                 pc_redirect_o,
    output logic [WIDTH-1:0]     mispredict_target_pc_o,
    output logic                 pc_predict_redirect_o,
    output logic [WIDTH-1:0]     predicted_target_pc_o,
    output logic                 slot1_kill_o,
    output logic                 flush_o,
    output logic [CNT_WIDTH-1:0] mispredict_count_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     pending_pc_q, pending_pc_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Ungated decisions; forced to zero below while reset is asserted.
    logic             pc_en;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             predict_redirect;
    logic [WIDTH-1:0] predict_redirect_pc;
    logic             slot1_kill;
    logic             flush;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d             = state_q;
        pending_pc_d        = pending_pc_q;
        flush_cnt_d         = flush_cnt_q;
        count_d             = count_q;
        pc_en               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = '0;
        predict_redirect    = 1'b0;
        predict_redirect_pc = '0;
        slot1_kill          = 1'b0;
        flush               = 1'b0;

        if (mispredict_i) begin
            // Execute's correction wins over everything, stalled or not.
            // Any parked predictor redirect was on the wrong path.
            redirect     = 1'b1;
            redirect_pc  = mispredict_pc_i;
            pc_en        = 1'b1;
            flush        = (state_q == FLUSH);
            state_d      = FLUSH;
            flush_cnt_d  = FLUSH_INIT;
            pending_pc_d = '0;
            if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    pc_en = !stall_i;
                    if (predict_taken_i) begin
                        // Slot 0 taken means the slot-1 instruction is past
                        // the branch and must not execute.
                        slot1_kill = !predict_slot_i;
                        if (!stall_i) begin
                            predict_redirect    = 1'b1;
                            predict_redirect_pc = predict_pc_i;
                        end else begin
                            pending_pc_d = predict_pc_i;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    pc_en = !stall_i;
                    if (!stall_i) begin
                        predict_redirect    = 1'b1;
                        predict_redirect_pc = pending_pc_q;
                        pending_pc_d        = '0;
                        state_d             = RUN;
                    end
                end
                FLUSH: begin
                    // Wrong-path fetches are squashed, so stalls and
                    // predictions from them are irrelevant.
                    flush       = 1'b1;
                    pc_en       = 1'b1;
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Outputs are decoded combinationally, so they are masked with rst_n to
    // read all-zero the moment reset asserts rather than at the next edge.
    always_comb begin
        pc_en_o                = rst_n & pc_en;
        pc_redirect_o          = rst_n & redirect;
        mispredict_target_pc_o = rst_n ? redirect_pc : '0;
        pc_predict_redirect_o  = rst_n & predict_redirect;
        predicted_target_pc_o  = rst_n ? predict_redirect_pc : '0;
        slot1_kill_o           = rst_n & slot1_kill;
        flush_o                = rst_n & flush;
        mispredict_count_o     = count_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pending_pc_q <= '0;
            flush_cnt_q  <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            flush_cnt_q  <= flush_cnt_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
//
// Scenario tasks drive one cycle at a time and push that cycle's expected
// outputs onto a queue; a negedge monitor pops and compares. The counter is
// narrowed to 8 bits so saturation is reachable in a few hundred cycles.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i;
    logic          mispredict_i;
    logic [W-1:0]  mispredict_pc_i;
    logic          predict_taken_i;
    logic          predict_slot_i;
    logic [W-1:0]  predict_pc_i;
    logic          pc_en_o;
    logic          pc_redirect_o;
    logic [W-1:0]  mispredict_target_pc_o;
    logic          pc_predict_redirect_o;
    logic [W-1:0]  predicted_target_pc_o;
    logic          slot1_kill_o;
    logic          flush_o;
    logic [CW-1:0] mispredict_count_o;

    fetch_redirect_ctrl #(
        .WIDTH(W),
        .FLUSH_CYCLES(2),
        .CNT_WIDTH(CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall_i               (stall_i),
        .mispredict_i          (mispredict_i),
        .mispredict_pc_i       (mispredict_pc_i),
        .predict_taken_i       (predict_taken_i),
        .predict_slot_i        (predict_slot_i),
        .predict_pc_i          (predict_pc_i),
        .pc_en_o               (pc_en_o),
        .pc_redirect_o         (pc_redirect_o),
        .mispredict_target_pc_o(mispredict_target_pc_o),
        .pc_predict_redirect_o (pc_predict_redirect_o),
        .predicted_target_pc_o (predicted_target_pc_o),
        .slot1_kill_o          (slot1_kill_o),
        .flush_o               (flush_o),
        .mispredict_count_o    (mispredict_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          redir;
        logic [W-1:0]  mtgt;
        logic          predir;
        logic [W-1:0]  ptgt;
        logic          kill;
        logic          flush;
        logic [CW-1:0] cnt;
        logic          loose;  // pc_en/flush not checked on mispredict cycles
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_vec   = 0;
    int            n_bad   = 0;

    // Scoreboard monitor: one expectation per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (pc_redirect_o !== e.redir) begin
                n_bad++; $display("FAIL redirect: got %b want %b @%0t", pc_redirect_o, e.redir, $time);
            end
            n_vec++;
            if (mispredict_target_pc_o !== e.mtgt) begin
                n_bad++; $display("FAIL mispredict_target: got %h want %h @%0t", mispredict_target_pc_o, e.mtgt, $time);
            end
            n_vec++;
            if (pc_predict_redirect_o !== e.predir) begin
                n_bad++; $display("FAIL predict_redirect: got %b want %b @%0t", pc_predict_redirect_o, e.predir, $time);
            end
            n_vec++;
            if (predicted_target_pc_o !== e.ptgt) begin
                n_bad++; $display("FAIL predicted_target: got %h want %h @%0t", predicted_target_pc_o, e.ptgt, $time);
            end
            n_vec++;
            if (slot1_kill_o !== e.kill) begin
                n_bad++; $display("FAIL slot1_kill: got %b want %b @%0t", slot1_kill_o, e.kill, $time);
            end
            n_vec++;
            if (mispredict_count_o !== e.cnt) begin
                n_bad++; $display("FAIL count: got %h want %h @%0t", mispredict_count_o, e.cnt, $time);
            end
            if (!e.loose) begin
                n_vec++;
                if (pc_en_o !== e.en) begin
                    n_bad++; $display("FAIL pc_en: got %b want %b @%0t", pc_en_o, e.en, $time);
                end
                n_vec++;
                if (flush_o !== e.flush) begin
                    n_bad++; $display("FAIL flush: got %b want %b @%0t", flush_o, e.flush, $time);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be. Called
    // at posedge+1; returns at the next posedge+1.
    task automatic drive(
        input logic st, input logic mp, input logic [W-1:0] mpc,
        input logic pt, input logic ps, input logic [W-1:0] ppc,
        input logic en, input logic redir, input logic [W-1:0] mtgt,
        input logic predir, input logic [W-1:0] ptgt,
        input logic kill, input logic fl, input logic loose);
        exp_t e;
        stall_i         = st;
        mispredict_i    = mp;
        mispredict_pc_i = mpc;
        predict_taken_i = pt;
        predict_slot_i  = ps;
        predict_pc_i    = ppc;
        e.en = en; e.redir = redir; e.mtgt = mtgt; e.predir = predir;
        e.ptgt = ptgt; e.kill = kill; e.flush = fl; e.cnt = exp_cnt; e.loose = loose;
        exp_q.push_back(e);
        // Count is registered: the increment shows from the next cycle on.
        if (mp && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_run();
        drive(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if ({pc_en_o, pc_redirect_o, pc_predict_redirect_o, slot1_kill_o, flush_o} !== 5'b0 ||
            mispredict_target_pc_o !== '0 || predicted_target_pc_o !== '0 ||
            mispredict_count_o !== '0) begin
            n_bad++;
            $display("FAIL %s: got en=%b rd=%b mt=%h pr=%b pt=%h k=%b f=%b c=%h want all zero",
                     tag, pc_en_o, pc_redirect_o, mispredict_target_pc_o, pc_predict_redirect_o,
                     predicted_target_pc_o, slot1_kill_o, flush_o, mispredict_count_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_i = 0; mispredict_i = 0; mispredict_pc_i = '0;
        predict_taken_i = 0; predict_slot_i = 0; predict_pc_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst_n = 1'b1;
        idle_run();
    endtask

    task automatic test_predict_unstalled();
        drive(0, 0, 0, 1, 0, 32'h40,  1, 0, 0, 1, 32'h40, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h44,  1, 0, 0, 1, 32'h44, 0, 0, 0);
    endtask

    task automatic test_predict_stalled();
        drive(1, 0, 0, 1, 1, 32'h80,  0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 32'h99,  0, 0, 0, 0, 0, 0, 0, 0);  // ignored in HOLD
        drive(1, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0,       1, 0, 0, 1, 32'h80, 0, 0, 0);
        idle_run();
    endtask

    task automatic test_mispredict_in_hold();
        drive(1, 0, 0,       1, 0, 32'h80,  0, 0, 0,       0, 0, 1, 0, 0);
        drive(1, 1, 32'h100, 0, 0, 0,       0, 1, 32'h100, 0, 0, 0, 0, 1);
        drive(1, 0, 0,       1, 0, 32'h300, 1, 0, 0,       0, 0, 0, 1, 0);
        drive(0, 0, 0,       0, 0, 0,       1, 0, 0,       0, 0, 0, 1, 0);
        idle_run();
        idle_run();
    endtask

    task automatic test_mispredict_in_flush();
        drive(0, 1, 32'h180, 0, 0, 0,      0, 1, 32'h180, 0, 0, 0, 0, 1);
        drive(0, 1, 32'h200, 1, 0, 32'h55, 0, 1, 32'h200, 0, 0, 0, 0, 1);
        drive(0, 0, 0,       1, 0, 32'h66, 1, 0, 0,       0, 0, 0, 1, 0);
        drive(1, 0, 0,       0, 0, 0,      1, 0, 0,       0, 0, 0, 1, 0);
        idle_run();
    endtask

    task automatic test_back_to_back_saturate();
        for (int i = 0; i < 260; i++) begin
            drive(i[0], 1, W'(i) << 2, 0, 0, 0,  0, 1, W'(i) << 2, 0, 0, 0, 0, 1);
        end
        drive(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0);
        // Reset mid-FLUSH with a mispredict and a prediction on the inputs.
        stall_i = 0; mispredict_i = 1; mispredict_pc_i = 32'hDEAD;
        predict_taken_i = 1; predict_slot_i = 0; predict_pc_i = 32'hBEEF;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_flush");
        @(posedge clk);
        #1;
        check_all_zero("reset_held_inputs_active");
        rst_n   = 1'b1;
        exp_cnt = '0;
        idle_run();
        drive(0, 0, 0, 1, 0, 32'h40,  1, 0, 0, 1, 32'h40, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_predict_unstalled();
        test_predict_stalled();
        test_mispredict_in_hold();
        test_mispredict_in_flush();
        test_back_to_back_saturate();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
